data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Data-memory access controller between the riscv_small data port and a word-wide, byte-enabled data memory.
- Converts a byte/half/word load or store into one aligned memory transaction.
- Manages the memory request/grant/read-valid handshake and returns a single-cycle data_ready to the core.
- Detects misaligned or illegal accesses and memory timeouts, reporting them as errors instead of touching memory.

Parameters:
- ADDR_W, 30, word-address width driven to memory (byte address bits [ADDR_W+1:2]).
- TIMEOUT_CYCLES, 16, cycles allowed in REQ or WAIT_R before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- clk_en  in  1  clock enable; all state frozen when low
- data_rd_en  in  1  core load request
- data_wr_en  in  1  core store request
- data_rd_wr_ctrl  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- data_addr  in  32  byte address (dataBus_u)
- data_wr  in  32  store data, right-justified (dataBus_u)
- data_rd  out  32  load data, right-justified, zero-extended (dataBus_u)
- data_ready  out  1  one-cycle completion pulse
- data_err  out  1  error flag, valid only while data_ready=1
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  lane-replicated write data
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word

Behaviour:
- Reset (rst_n=0 at posedge clk with clk_en=1): state IDLE; data_ready, data_err, mem_req, mem_we=0; mem_be=0; mem_addr, mem_wdata, data_rd=0; timeout counter=0.
- clk_en=0: no state, counter or output changes.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE: inputs are sampled only in this state.
  - Legal request: register address, size, lane-aligned wdata and be into the mem_* outputs; go to REQ.
  - Illegal request: go to RESP with err=1; memory is untouched.
  - Illegal means any of: rd_en and wr_en both high; size=11; half with addr[0]=1; word with addr[1:0]!=0.
- REQ: mem_req=1; all mem_* outputs held stable until mem_gnt.
  - On gnt, write: go to RESP.
  - On gnt, read: go to WAIT_R. mem_rvalid in the gnt cycle is ignored.
- WAIT_R: mem_req=0. On mem_rvalid, register the extracted lanes into data_rd, then go to RESP.
- Timeout: counter clears on entry to REQ and WAIT_R and increments each enabled cycle there. When it reaches TIMEOUT_CYCLES, go to RESP with err=1, drop mem_req, and leave data_rd unchanged.
- RESP: data_ready=1 for exactly one cycle; data_err as latched; core inputs ignored; next state IDLE.
  - A request still held by the core is re-sampled in IDLE, so the core must drop its enables on the data_ready cycle.
- Latency, request sampled in cycle N:
  - mem_req high from N+1.
  - Write with immediate gnt: data_ready at N+2.
  - Read with gnt at N+1 and rvalid at N+2: data_ready at N+3.
  - Illegal request: data_ready and data_err at N+1.
- Lane rules, o = addr[1:0]:
  - byte: be = 4'b0001 << o; wdata = {4{data_wr[7:0]}}; data_rd = {24'b0, rdata[8o+7:8o]}.
  - half: be = 4'b0011 << o; wdata = {2{data_wr[15:0]}}; data_rd = {16'b0, rdata[8o+15:8o]}.
  - word: be = 4'b1111; wdata and data_rd pass through unchanged.
  - Sign extension stays in the core.
- Reset asserted mid-transaction returns to IDLE next edge with mem_req=0. Memory must tolerate an abandoned request.

Decomposition:
- riscv_definitions additions:
  - mem_size_e enum (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10).
  - dmc_state_e enum (IDLE, REQ, WAIT_R, RESP).
  - localparam DMC_TIMEOUT_DEFAULT = 16.
- Sub-module data_lane_align (combinational):
  - inputs: size, offset, store data, memory read data.
  - outputs: be, replicated wdata, extracted rdata.
  - The FSM owns all registers.

Test Plan:
- SW addr 0x0000_0010, data 0xDEADBEEF, gnt immediate -> mem_addr=0x4, be=1111, wdata=0xDEADBEEF; data_ready at N+2, err=0.
- SB addr 0x13, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5. Then LB addr 0x13 with rdata 0xA5000000, rvalid 1 cycle after gnt -> data_rd=0x000000A5 at N+3.
- LH addr 0x22, rdata 0x12345678, gnt delayed 3 cycles -> mem_req held stable 4 cycles, be=1100, data_rd=0x00001234.
- LW addr 0x01; SH addr 0x03; ctrl=11; rd_en=wr_en=1 -> each gives data_ready+data_err at N+1 with mem_req never asserted.
- LW with mem_gnt tied low, TIMEOUT_CYCLES=16 -> mem_req deasserts after 16 cycles in REQ, data_ready+data_err pulse, FSM back to IDLE.
- clk_en low for 5 cycles during WAIT_R with rvalid low, then rvalid -> completion delayed exactly 5 cycles. Separately, rst_n low in WAIT_R -> IDLE and all outputs 0 next edge.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Contents:
//   mem_size_e          - access size encoding used on data_rd_wr_ctrl
//   dmc_state_e         - controller FSM states
//   DMC_TIMEOUT_DEFAULT - default memory handshake timeout in cycles
//   dmc_access_illegal  - classifies a core request as illegal
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    RESP
  } dmc_state_e;

  localparam int unsigned DMC_TIMEOUT_DEFAULT = 16;

  // A request is illegal when both directions are asked for at once, the
  // size code is reserved, or the address is not naturally aligned.
  function automatic logic dmc_access_illegal(
    input logic       rd_en,
    input logic       wr_en,
    input logic [1:0] size,
    input logic [1:0] offset
  );
    logic bad;
    bad = rd_en && wr_en;
    case (size)
      MEM_BYTE: bad = bad;
      MEM_HALF: bad = bad || offset[0];
      MEM_WORD: bad = bad || (offset != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane.sv
// data_lane_align: combinational byte-lane steering between the core's
// right-justified data and the word-wide, byte-enabled memory.
// Ports:
//   size     - access size (mem_size_e encoding; 2'b11 yields no lanes)
//   offset   - byte offset within the word (address bits [1:0])
//   st_data  - right-justified store data from the core
//   rd_word  - full read word from memory
//   be       - byte enables for the access
//   wdata    - store data replicated across all lanes
//   rd_data  - selected lanes, right-justified and zero-extended
module data_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rd_data
);

  logic [31:0] rd_shifted;

  always_comb begin
    be         = '0;
    wdata      = st_data;
    rd_data    = '0;
    // Bring the addressed lane down to bit 0 once; each size then just masks.
    rd_shifted = rd_word >> {offset, 3'b000};
    case (size)
      MEM_BYTE: begin
        be      = 4'b0001 << offset;
        wdata   = {4{st_data[7:0]}};
        rd_data = {24'b0, rd_shifted[7:0]};
      end
      MEM_HALF: begin
        be      = 4'b0011 << offset;
        wdata   = {2{st_data[15:0]}};
        rd_data = {16'b0, rd_shifted[15:0]};
      end
      MEM_WORD: begin
        be      = '1;
        wdata   = st_data;
        rd_data = rd_word;
      end
      default: begin
        be      = '0;
        wdata   = st_data;
        rd_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory access controller between the core data port
// and a word-wide byte-enabled memory. Each core load/store becomes one
// aligned memory transaction; misaligned/illegal accesses and memory
// timeouts complete with data_err instead of touching memory.
// Ports:
//   clk, rst_n, clk_en                     - clock, sync active-low reset, clock enable
//   data_rd_en, data_wr_en                 - core load / store request
//   data_rd_wr_ctrl                        - access size (byte/half/word/illegal)
//   data_addr, data_wr                     - byte address, right-justified store data
//   data_rd, data_ready, data_err          - load data, completion pulse, error flag
//   mem_req, mem_we, mem_be, mem_addr,
//   mem_wdata                              - memory request side
//   mem_gnt, mem_rvalid, mem_rdata         - memory response side
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 30,
  parameter int unsigned TIMEOUT_CYCLES = DMC_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              data_rd_en,
  input  logic              data_wr_en,
  input  logic [1:0]        data_rd_wr_ctrl,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wr,
  output logic [31:0]       data_rd,
  output logic              data_ready,
  output logic              data_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned     CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              TO_EN     = (TIMEOUT_CYCLES != 0);

  dmc_state_e        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        offset_q, offset_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              timeout_hit;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       data_rd_q, data_rd_d;

  logic              req_valid;
  logic              req_illegal;
  logic [1:0]        lane_size;
  logic [1:0]        lane_offset;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;

  if (ADDR_W < 30) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^data_addr[31:ADDR_W+2];
  end

  assign req_valid   = data_rd_en || data_wr_en;
  assign req_illegal = dmc_access_illegal(data_rd_en, data_wr_en,
                                          data_rd_wr_ctrl, data_addr[1:0]);

  // One aligner serves both directions: in IDLE it steers the incoming
  // store, afterwards it extracts read lanes using the captured size/offset.
  assign lane_size   = (state_q == IDLE) ? data_rd_wr_ctrl : size_q;
  assign lane_offset = (state_q == IDLE) ? data_addr[1:0]  : offset_q;

  data_lane_align u_lane (
    .size    (lane_size),
    .offset  (lane_offset),
    .st_data (data_wr),
    .rd_word (mem_rdata),
    .be      (lane_be),
    .wdata   (lane_wdata),
    .rd_data (lane_rdata)
  );

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = TO_EN && (cnt_inc == CNT_LIMIT);

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    offset_d    = offset_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_rd_d   = data_rd_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d     = REQ;
            err_d       = 1'b0;
            cnt_d       = '0;
            size_d      = data_rd_wr_ctrl;
            offset_d    = data_addr[1:0];
            mem_we_d    = data_wr_en;
            mem_be_d    = lane_be;
            mem_addr_d  = data_addr[ADDR_W+1:2];
            mem_wdata_d = lane_wdata;
          end
        end
      end
      REQ: begin
        // A grant wins over a timeout landing in the same cycle.
        if (mem_gnt) begin
          state_d = mem_we_q ? RESP : WAIT_R;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          data_rd_d = lane_rdata;
          state_d   = RESP;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (!rst_n) begin
        state_q     <= IDLE;
        size_q      <= '0;
        offset_q    <= '0;
        err_q       <= 1'b0;
        cnt_q       <= '0;
        mem_we_q    <= 1'b0;
        mem_be_q    <= '0;
        mem_addr_q  <= '0;
        mem_wdata_q <= '0;
        data_rd_q   <= '0;
      end else begin
        state_q     <= state_d;
        size_q      <= size_d;
        offset_q    <= offset_d;
        err_q       <= err_d;
        cnt_q       <= cnt_d;
        mem_we_q    <= mem_we_d;
        mem_be_q    <= mem_be_d;
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
        data_rd_q   <= data_rd_d;
      end
    end
  end

  assign mem_req    = (state_q == REQ);
  assign data_ready = (state_q == RESP);
  assign data_err   = data_ready && err_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign data_rd    = data_rd_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a behavioural memory that grants
// and returns read data after programmable delays, plus a scoreboard of
// expected core responses and expected memory transactions.
module tb_data_mem_ctrl;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned TO     = 16;

  logic              clk = 1'b0;
  logic              rst_n, clk_en;
  logic              data_rd_en, data_wr_en;
  logic [1:0]        data_rd_wr_ctrl;
  logic [31:0]       data_addr, data_wr, data_rd;
  logic              data_ready, data_err;
  logic              mem_req, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt, mem_rvalid;
  logic [31:0]       mem_rdata;

  data_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clk_en          (clk_en),
    .data_rd_en      (data_rd_en),
    .data_wr_en      (data_wr_en),
    .data_rd_wr_ctrl (data_rd_wr_ctrl),
    .data_addr       (data_addr),
    .data_wr         (data_wr),
    .data_rd         (data_rd),
    .data_ready      (data_ready),
    .data_err        (data_err),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_be          (mem_be),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_gnt         (mem_gnt),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          t0;
    int          lat;
  } rsp_t;

  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } mtx_t;

  rsp_t exp_q[$];
  mtx_t mem_q[$];
  logic [31:0] prev_rd = '0;

  // Reference lane model, written as explicit tables.
  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] o);
    case (sz)
      2'b00: case (o)
               2'd0: return 4'b0001;
               2'd1: return 4'b0010;
               2'd2: return 4'b0100;
               default: return 4'b1000;
             endcase
      2'b01: return (o == 2'd0) ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_rd(input logic [1:0] sz, input logic [1:0] o, input logic [31:0] w);
    case (sz)
      2'b00: case (o)
               2'd0: return {24'h0, w[7:0]};
               2'd1: return {24'h0, w[15:8]};
               2'd2: return {24'h0, w[23:16]};
               default: return {24'h0, w[31:24]};
             endcase
      2'b01: return (o == 2'd0) ? {16'h0, w[15:0]} : {16'h0, w[31:16]};
      default: return w;
    endcase
  endfunction

  // Behavioural memory
  int          gnt_delay = 0;
  int          rv_delay  = 1;
  logic [31:0] rdata_val = '0;
  int          req_cnt = 0, rv_cnt = 0, last_req_len = 0, req_total = 0;
  bit          rv_pend = 1'b0;
  mtx_t        m_head;

  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom();
    if (rv_pend) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        rv_pend    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata_val;
      end
    end
    if (mem_req === 1'b1) begin
      req_total++;
      req_cnt++;
      if (mem_q.size() == 0) begin
        check("unexpected_mem_req", 32'(mem_req), 32'd0);
      end else begin
        m_head = mem_q[0];
        check("mem_we",    32'(mem_we),    32'(m_head.we));
        check("mem_be",    32'(mem_be),    32'(m_head.be));
        check("mem_addr",  32'(mem_addr),  32'(m_head.addr));
        check("mem_wdata", mem_wdata,      m_head.wdata);
        if (req_cnt == gnt_delay + 1) begin
          mem_gnt = 1'b1;
          void'(mem_q.pop_front());
          if (!m_head.we) begin
            rv_pend    = 1'b1;
            rv_cnt     = rv_delay;
            // rvalid in the grant cycle must be ignored
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBADBADBA;
          end
        end
      end
    end else if (req_cnt != 0) begin
      last_req_len = req_cnt;
      req_cnt      = 0;
    end
  end

  // Response monitor
  rsp_t mon_r;
  always @(negedge clk) begin
    if (data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", 32'(data_ready), 32'd0);
      end else begin
        mon_r = exp_q.pop_front();
        check("data_err", 32'(data_err), 32'(mon_r.err));
        check("data_rd",  data_rd, mon_r.rd);
        check("latency",  32'(cyc - mon_r.t0), 32'(mon_r.lat));
      end
    end else if (data_err === 1'b1) begin
      check("err_without_ready", 32'(data_err), 32'd0);
    end
  end

  // Drive one request for one cycle; gd >= 1000 means the memory never grants.
  task automatic send(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int gd, input int rv, input logic [31:0] word);
    rsp_t       r;
    mtx_t       m;
    logic [1:0] o;
    bit         ill;
    o   = addr[1:0];
    ill = (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && o[0]) || (sz == 2'b10 && o != 2'd0);
    gnt_delay = gd;
    rv_delay  = rv;
    rdata_val = word;
    @(negedge clk);
    r.t0  = cyc;
    r.err = ill;
    r.rd  = prev_rd;
    if (ill) begin
      r.lat = 1;
    end else if (gd >= 1000) begin
      r.lat = TO + 1;
      r.err = 1'b1;
    end else if (rd) begin
      r.lat = gd + rv + 2;
      r.rd  = ref_rd(sz, o, word);
    end else begin
      r.lat = gd + 2;
    end
    prev_rd = r.rd;
    exp_q.push_back(r);
    if (!ill) begin
      m.we    = wr;
      m.be    = ref_be(sz, o);
      m.addr  = addr[ADDR_W+1:2];
      m.wdata = ref_wd(sz, wd);
      mem_q.push_back(m);
    end
    data_rd_en      = rd;
    data_wr_en      = wr;
    data_rd_wr_ctrl = sz;
    data_addr       = addr;
    data_wr         = wd;
    @(negedge clk);
    data_rd_en = 1'b0;
    data_wr_en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_no_ready"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      mem_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},    32'(mem_req),    32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_be"},     32'(mem_be),     32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    check({tag, "_data_rd"},    data_rd,         32'd0);
    check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
    check({tag, "_data_err"},   32'(data_err),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int          req_before;
  logic [1:0]  r_sz;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic        r_rd;

  initial begin
    rst_n = 1'b0; clk_en = 1'b1;
    data_rd_en = 1'b0; data_wr_en = 1'b0; data_rd_wr_ctrl = 2'b00;
    data_addr = '0; data_wr = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Aligned word store, immediate grant
    send(1'b0, 1'b1, 2'b10, 32'h0000_0010, 32'hDEADBEEF, 0, 1, '0);
    wait_done("sw");
    // Byte store to the top lane, then read it back
    send(1'b0, 1'b1, 2'b00, 32'h0000_0013, 32'h0000_00A5, 0, 1, '0);
    wait_done("sb");
    send(1'b1, 1'b0, 2'b00, 32'h0000_0013, '0, 0, 1, 32'hA500_0000);
    wait_done("lb");
    // Half load with grant delayed 3 cycles
    send(1'b1, 1'b0, 2'b01, 32'h0000_0022, '0, 3, 1, 32'h1234_5678);
    wait_done("lh");
    check("lh_req_len", 32'(last_req_len), 32'd4);

    // Illegal requests never reach memory
    req_before = req_total;
    send(1'b1, 1'b0, 2'b10, 32'h0000_0001, '0, 0, 1, '0);
    wait_done("ill_lw");
    send(1'b0, 1'b1, 2'b01, 32'h0000_0003, 32'h1111_2222, 0, 1, '0);
    wait_done("ill_sh");
    send(1'b1, 1'b0, 2'b11, 32'h0000_0000, '0, 0, 1, '0);
    wait_done("ill_size");
    send(1'b1, 1'b1, 2'b10, 32'h0000_0000, '0, 0, 1, '0);
    wait_done("ill_rdwr");
    check("illegal_no_req", 32'(req_total - req_before), 32'd0);

    // Grant never arrives
    send(1'b1, 1'b0, 2'b10, 32'h0000_0040, '0, 1000, 1, '0);
    wait_done("timeout");
    check("timeout_req_len", 32'(last_req_len), TO);
    mem_q.delete();
    // Controller is usable again afterwards
    send(1'b1, 1'b0, 2'b10, 32'h0000_0040, '0, 0, 1, 32'hCAFE_F00D);
    wait_done("after_to");

    // Clock enable frozen for 5 cycles while waiting on read data
    send(1'b1, 1'b0, 2'b00, 32'h0000_0101, '0, 0, 6, 32'h0000_CD00);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (5) @(negedge clk);
    clk_en = 1'b1;
    wait_done("clk_en");

    // Mixed legal traffic with random alignment and delays
    for (int i = 0; i < 12; i++) begin
      r_sz   = 2'($urandom_range(0, 2));
      r_off  = (r_sz == 2'b00) ? 2'($urandom_range(0, 3)) :
               (r_sz == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      r_addr = $urandom();
      r_addr = {r_addr[31:2], r_off};
      r_rd   = 1'($urandom_range(0, 1));
      send(r_rd, !r_rd, r_sz, r_addr, $urandom(), $urandom_range(0, 3),
           $urandom_range(1, 3), $urandom());
      wait_done("rand");
    end

    // Reset while waiting for read data
    send(1'b1, 1'b0, 2'b10, 32'h0000_0080, '0, 0, 20, 32'h5555_AAAA);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    exp_q.delete();
    prev_rd = '0;
    repeat (25) @(negedge clk);
    send(1'b1, 1'b0, 2'b01, 32'h0000_0086, '0, 1, 2, 32'hBEEF_0123);
    wait_done("post_reset");

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
